// File: rtl/urv_dm_wb_bridge_if.sv
// Core data-memory request port plus Wishbone classic master signals.
// slave = bridge view, master = core/bus-slave view.
interface urv_dm_wb_bridge_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_bus_error_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i,
    input  dm_load_i, dm_store_i,
    output dm_ready_o, dm_data_l_o,
    output dm_load_done_o, dm_store_done_o, dm_bus_error_o,
    output wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i,
    output dm_load_i, dm_store_i,
    input  dm_ready_o, dm_data_l_o,
    input  dm_load_done_o, dm_store_done_o, dm_bus_error_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/urv_dm_wb_bridge.sv
// Data-memory request to Wishbone classic bridge, one bus cycle per request.
// Optional bus timeout enabled by defining URV_DM_WB_TIMEOUT_EN.
module urv_dm_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst_i,
  urv_dm_wb_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ready;
  logic [31:0] r_data_l;
  logic        r_load_done;
  logic        r_store_done;
  logic        r_bus_err;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_cyc;
  logic        r_stb;

  logic        w_ready;
  logic [31:0] w_data_l;
  logic        w_load_done;
  logic        w_store_done;
  logic        w_bus_err;
  logic [31:0] w_adr;
  logic [31:0] w_dat;
  logic [3:0]  w_sel;
  logic        w_we;
  logic        w_cyc;
  logic        w_stb;

  logic w_req;
  logic w_end;
  logic w_to;

  assign w_req = bus.dm_load_i | bus.dm_store_i;

`ifdef URV_DM_WB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  assign w_to = (r_cnt == 16'(TIMEOUT_CYCLES - 1))
              & ~bus.wb_ack_i & ~bus.wb_err_i;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == S_BUS) w_cnt_nxt = r_cnt + 16'd1;
    else if (w_req)       w_cnt_nxt = 16'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_cnt <= 16'd0;
    else       r_cnt <= w_cnt_nxt;
  end
`else
  assign w_to = 1'b0;
`endif

  assign w_end = bus.wb_ack_i | bus.wb_err_i | w_to;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_data_l     <= '0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_bus_err    <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_we         <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready;
      r_data_l     <= w_data_l;
      r_load_done  <= w_load_done;
      r_store_done <= w_store_done;
      r_bus_err    <= w_bus_err;
      r_adr        <= w_adr;
      r_dat        <= w_dat;
      r_sel        <= w_sel;
      r_we         <= w_we;
      r_cyc        <= w_cyc;
      r_stb        <= w_stb;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_req ? S_BUS : S_IDLE;
      S_BUS:          w_state_nxt = w_end ? S_DONE : S_BUS;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_ready      = r_ready;
    w_data_l     = r_data_l;
    w_load_done  = 1'b0;
    w_store_done = 1'b0;
    w_bus_err    = 1'b0;
    w_adr        = r_adr;
    w_dat        = r_dat;
    w_sel        = r_sel;
    w_we         = r_we;
    w_cyc        = r_cyc;
    w_stb        = r_stb;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_ready = ~w_req;
        w_cyc   = w_req;
        w_stb   = w_req;
        if (w_req) begin
          w_adr = bus.dm_addr_i & 32'hFFFF_FFFC;
          w_dat = bus.dm_data_s_i;
          w_sel = bus.dm_data_select_i;
          w_we  = bus.dm_store_i;
        end
      end
      S_BUS: begin
        if (w_end) begin
          w_ready      = 1'b1;
          w_cyc        = 1'b0;
          w_stb        = 1'b0;
          w_load_done  = ~r_we;
          w_store_done = r_we;
          w_bus_err    = bus.wb_err_i | w_to;
          if (!r_we && bus.wb_ack_i && !bus.wb_err_i)
            w_data_l = bus.wb_dat_i;
          else if (!r_we && w_to)
            w_data_l = 32'hDEAD_BEEF;
        end
      end
      default: begin
        w_ready = 1'b1;
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
      end
    endcase
  end

  assign bus.dm_ready_o      = r_ready;
  assign bus.dm_data_l_o     = r_data_l;
  assign bus.dm_load_done_o  = r_load_done;
  assign bus.dm_store_done_o = r_store_done;
  assign bus.dm_bus_error_o  = r_bus_err;
  assign bus.wb_adr_o        = r_adr;
  assign bus.wb_dat_o        = r_dat;
  assign bus.wb_sel_o        = r_sel;
  assign bus.wb_we_o         = r_we;
  assign bus.wb_cyc_o        = r_cyc;
  assign bus.wb_stb_o        = r_stb;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Directed self-checking bench for urv_dm_wb_bridge.
// Timeout scenario runs when URV_DM_WB_TIMEOUT_EN is defined.
module tb_urv_dm_wb_bridge;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  urv_dm_wb_bridge_if bus ();

  urv_dm_wb_bridge #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cyc, stb, we, ready, load_done, store_done, bus_err}
  logic [6:0] st;
  assign st = {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
               bus.dm_ready_o, bus.dm_load_done_o,
               bus.dm_store_done_o, bus.dm_bus_error_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dm_addr_i        = '0;
    bus.dm_data_s_i      = '0;
    bus.dm_data_select_i = '0;
    bus.dm_load_i        = 1'b0;
    bus.dm_store_i       = 1'b0;
    bus.wb_dat_i         = '0;
    bus.wb_ack_i         = 1'b0;
    bus.wb_err_i         = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if (st !== 7'b0001000) begin
      n_err++;
      $display("FAIL reset_status: got %b want %b", st, 7'b0001000);
    end
    n_chk++;
    if ({bus.dm_data_l_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h %h want zeros",
               bus.dm_data_l_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o);
    end
  endtask

  task automatic test_load_zero_wait();
    bus.dm_load_i = 1'b1;
    bus.dm_addr_i = 32'h0000_1004;
    tick();
    bus.dm_load_i = 1'b0;
    n_chk++;
    if (st !== 7'b1100000) begin
      n_err++;
      $display("FAIL load_bus_status: got %b want %b", st, 7'b1100000);
    end
    n_chk++;
    if (bus.wb_adr_o !== 32'h0000_1004) begin
      n_err++;
      $display("FAIL load_adr: got %h want %h", bus.wb_adr_o, 32'h1004);
    end
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hCAFE_F00D;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    n_chk++;
    if (st !== 7'b0001100) begin
      n_err++;
      $display("FAIL load_done_status: got %b want %b", st, 7'b0001100);
    end
    n_chk++;
    if (bus.dm_data_l_o !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL load_data: got %h want %h", bus.dm_data_l_o, 32'hCAFEF00D);
    end
    tick();
    n_chk++;
    if (st !== 7'b0001000) begin
      n_err++;
      $display("FAIL load_pulse_end: got %b want %b", st, 7'b0001000);
    end
  endtask

  task automatic test_store_wait3();
    bus.dm_store_i       = 1'b1;
    bus.dm_addr_i        = 32'h0000_2002;
    bus.dm_data_s_i      = 32'h55AA_55AA;
    bus.dm_data_select_i = 4'b1100;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.wb_ack_i = 1'b1;
      n_chk++;
      if ({st, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o} !==
          {7'b1110000, 32'h0000_2000, 32'h55AA_55AA, 4'b1100}) begin
        n_err++;
        $display("FAIL store_hold[%0d]: got %b %h %h %b want %b %h %h %b",
                 i, st, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o,
                 7'b1110000, 32'h2000, 32'h55AA55AA, 4'b1100);
      end
      tick();
    end
    bus.wb_ack_i = 1'b0;
    n_chk++;
    if (st !== 7'b0011010) begin
      n_err++;
      $display("FAIL store_done_status: got %b want %b", st, 7'b0011010);
    end
    n_chk++;
    if (bus.dm_data_l_o !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL store_keeps_data: got %h want %h", bus.dm_data_l_o, 32'hCAFEF00D);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.dm_store_i  = 1'b1;
    bus.dm_addr_i   = 32'h0000_3010;
    bus.dm_data_s_i = 32'h0BAD_F00D;
    bus.dm_data_select_i = 4'b1111;
    tick();
    idle_inputs();
    bus.wb_ack_i = 1'b1;
    tick();
    bus.wb_ack_i  = 1'b0;
    n_chk++;
    if (st !== 7'b0011010) begin
      n_err++;
      $display("FAIL b2b_store_done: got %b want %b", st, 7'b0011010);
    end
    bus.dm_load_i = 1'b1;
    bus.dm_addr_i = 32'h0000_3000;
    tick();
    bus.dm_load_i = 1'b0;
    n_chk++;
    if ({st, bus.wb_adr_o} !== {7'b1100000, 32'h0000_3000}) begin
      n_err++;
      $display("FAIL b2b_load_bus: got %b %h want %b %h",
               st, bus.wb_adr_o, 7'b1100000, 32'h3000);
    end
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h1234_5678;
    tick();
    idle_inputs();
    n_chk++;
    if ({st, bus.dm_data_l_o} !== {7'b0001100, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL b2b_load_done: got %b %h want %b %h",
               st, bus.dm_data_l_o, 7'b0001100, 32'h12345678);
    end
    tick();
  endtask

  task automatic test_error();
    bus.dm_load_i = 1'b1;
    bus.dm_addr_i = 32'h0000_4000;
    tick();
    bus.dm_load_i = 1'b0;
    bus.wb_ack_i  = 1'b1;
    bus.wb_err_i  = 1'b1;
    bus.wb_dat_i  = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    n_chk++;
    if ({st, bus.dm_data_l_o} !== {7'b0001101, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL err_load: got %b %h want %b %h",
               st, bus.dm_data_l_o, 7'b0001101, 32'h12345678);
    end
    tick();
  endtask

  task automatic test_load_store_both();
    bus.dm_load_i   = 1'b1;
    bus.dm_store_i  = 1'b1;
    bus.dm_addr_i   = 32'h0000_4444;
    bus.dm_data_s_i = 32'h0000_0001;
    bus.dm_data_select_i = 4'b0001;
    tick();
    idle_inputs();
    n_chk++;
    if (st !== 7'b1110000) begin
      n_err++;
      $display("FAIL both_is_store: got %b want %b", st, 7'b1110000);
    end
    bus.wb_ack_i = 1'b1;
    tick();
    bus.wb_ack_i = 1'b0;
    n_chk++;
    if (st !== 7'b0011010) begin
      n_err++;
      $display("FAIL both_done: got %b want %b", st, 7'b0011010);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dm_load_i = 1'b1;
    bus.dm_addr_i = 32'h0000_5000;
    tick();
    bus.dm_load_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (st !== 7'b0001000) begin
      n_err++;
      $display("FAIL rst_mid_status: got %b want %b", st, 7'b0001000);
    end
    tick();
    n_chk++;
    if (st !== 7'b0001000) begin
      n_err++;
      $display("FAIL rst_mid_no_done: got %b want %b", st, 7'b0001000);
    end
    bus.dm_load_i = 1'b1;
    bus.dm_addr_i = 32'h0000_6000;
    tick();
    bus.dm_load_i = 1'b0;
    bus.wb_ack_i  = 1'b1;
    bus.wb_dat_i  = 32'hA5A5_5A5A;
    tick();
    idle_inputs();
    n_chk++;
    if ({st, bus.dm_data_l_o} !== {7'b0001100, 32'hA5A5_5A5A}) begin
      n_err++;
      $display("FAIL rst_mid_next_load: got %b %h want %b %h",
               st, bus.dm_data_l_o, 7'b0001100, 32'hA5A55A5A);
    end
    tick();
  endtask

  task automatic test_silent_slave();
    bus.dm_load_i = 1'b1;
    bus.dm_addr_i = 32'h0000_7000;
    tick();
    bus.dm_load_i = 1'b0;
`ifdef URV_DM_WB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (st !== 7'b1100000) begin
        n_err++;
        $display("FAIL to_wait[%0d]: got %b want %b", i, st, 7'b1100000);
      end
      tick();
    end
    n_chk++;
    if ({st, bus.dm_data_l_o} !== {7'b0001101, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL to_abort: got %b %h want %b %h",
               st, bus.dm_data_l_o, 7'b0001101, 32'hDEADBEEF);
    end
`else
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (st !== 7'b1100000) begin
        n_err++;
        $display("FAIL no_to_wait[%0d]: got %b want %b", i, st, 7'b1100000);
      end
      tick();
    end
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h0F0F_0F0F;
    tick();
    idle_inputs();
    n_chk++;
    if ({st, bus.dm_data_l_o} !== {7'b0001100, 32'h0F0F_0F0F}) begin
      n_err++;
      $display("FAIL no_to_done: got %b %h want %b %h",
               st, bus.dm_data_l_o, 7'b0001100, 32'h0F0F0F0F);
    end
`endif
    tick();
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_load_zero_wait();
    test_store_wait3();
    test_back_to_back();
    test_error();
    test_load_store_both();
    test_reset_mid();
    test_silent_slave();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
